// File: rtl/pc_sequencer_if.sv
// Decode-to-PC request bundle plus the PC-side results fed to instruction fetch.
interface pc_sequencer_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 stall;
    logic                 req_valid;
    logic [1:0]           bs;
    logic                 ps;
    logic                 z;
    logic [WIDTH-1:0]     bra;
    logic [WIDTH-1:0]     raa;
    logic                 cnt_clr;
    logic [WIDTH-1:0]     pc;
    logic [WIDTH-1:0]     pc_inc;
    logic                 flush;
    logic                 taken;
    logic [CNT_WIDTH-1:0] taken_cnt;

    modport master (
        output stall, req_valid, bs, ps, z, bra, raa, cnt_clr,
        input  pc, pc_inc, flush, taken, taken_cnt
    );

    modport slave (
        input  stall, req_valid, bs, ps, z, bra, raa, cnt_clr,
        output pc, pc_inc, flush, taken, taken_cnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// Registered program counter: picks increment / branch / register-jump targets,
// squashes decode for a fixed window after each taken redirect, counts redirects.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_PC     = '0,
    parameter int               INCR         = 1,
    parameter int               FLUSH_CYCLES = 2,
    parameter int               CNT_WIDTH    = 16
) (
    input logic         clk,
    input logic         rst_n,
    pc_sequencer_if.slave bus
);

    typedef enum logic {RUN, FLUSH} state_t;

    typedef struct packed {
        logic             taken;
        logic [WIDTH-1:0] target;
    } redirect_t;

    localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [WIDTH-1:0] INCR_W     = WIDTH'(INCR);

    state_t               state_q;
    logic [3:0]           fcnt_q;
    logic [WIDTH-1:0]     pc_q;
    logic                 taken_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic [WIDTH-1:0]     pc_inc_d;
    logic [CNT_WIDTH-1:0] cnt_inc_d;
    logic                 accept_d;
    redirect_t            redir_d;

    assign pc_inc_d  = pc_q + INCR_W;
    assign cnt_inc_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign accept_d  = bus.req_valid && (state_q == RUN);

    always_comb begin
        redir_d = '{taken: 1'b0, target: pc_inc_d};
        if (accept_d) begin
            unique case (bus.bs)
                2'b01: if (bus.ps ^ bus.z) redir_d = '{taken: 1'b1, target: bus.bra};
                2'b10: redir_d = '{taken: 1'b1, target: bus.raa};
                2'b11: redir_d = '{taken: 1'b1, target: bus.bra};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
            cnt_q   <= '0;
        end else if (bus.stall) begin
            // Everything freezes, including a pending taken pulse; only the
            // counter clear still lands.
            if (bus.cnt_clr) cnt_q <= '0;
        end else begin
            taken_q <= 1'b0;
            unique case (state_q)
                RUN: begin
                    pc_q <= redir_d.target;
                    if (redir_d.taken) begin
                        taken_q <= 1'b1;
                        state_q <= FLUSH;
                        fcnt_q  <= FLUSH_LOAD;
                        cnt_q   <= bus.cnt_clr ? CNT_WIDTH'(1) : cnt_inc_d;
                    end else if (bus.cnt_clr) begin
                        cnt_q <= '0;
                    end
                end
                FLUSH: begin
                    pc_q <= pc_inc_d;
                    if (fcnt_q == 4'd0) state_q <= RUN;
                    else                fcnt_q  <= fcnt_q - 4'd1;
                    if (bus.cnt_clr) cnt_q <= '0;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_inc    = pc_inc_d;
    assign bus.flush     = (state_q == FLUSH);
    assign bus.taken     = taken_q;
    assign bus.taken_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (WIDTH=32, RESET_PC=0, INCR=1, FLUSH_CYCLES=2, CNT_WIDTH=2).
module tb_pc_sequencer;
    localparam int W  = 32;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   cmp  = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

    pc_sequencer #(
        .WIDTH(W), .RESET_PC('0), .INCR(1), .FLUSH_CYCLES(2), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic fl,
                           input logic tk, input logic [1:0] cnt);
        chk({tag, ".pc"},    64'(bus.pc),        64'(pc));
        chk({tag, ".flush"}, 64'(bus.flush),     64'(fl));
        chk({tag, ".taken"}, 64'(bus.taken),     64'(tk));
        chk({tag, ".cnt"},   64'(bus.taken_cnt), 64'(cnt));
    endtask

    task automatic set_req(input logic rv, input logic [1:0] bs, input logic ps,
                           input logic z, input logic [31:0] bra, input logic [31:0] raa);
        bus.req_valid = rv; bus.bs = bs; bus.ps = ps; bus.z = z;
        bus.bra = bra; bus.raa = raa;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.stall = 1'b0; bus.cnt_clr = 1'b0;
        set_req(1'b0, 2'b00, 1'b0, 1'b0, '0, '0);
        #12;
        chk_all("reset", 32'h0, 1'b0, 1'b0, 2'd0);
        @(negedge clk); rst_n = 1'b1;

        // sequential run
        for (int i = 1; i <= 4; i++) begin
            step();
            chk_all("seq", 32'(i), 1'b0, 1'b0, 2'd0);
            chk("seq.pc_inc", 64'(bus.pc_inc), 64'(i + 1));
        end

        // jump to 0x0E; a redirect request during FLUSH must be squashed
        set_req(1'b1, 2'b10, 1'b0, 1'b0, '0, 32'h0E);
        step(); chk_all("jr", 32'h0E, 1'b1, 1'b1, 2'd1);
        set_req(1'b1, 2'b10, 1'b0, 1'b0, '0, 32'h200);
        step(); chk_all("squash1", 32'h0F, 1'b1, 1'b0, 2'd1);
        step(); chk_all("squash2", 32'h10, 1'b0, 1'b0, 2'd1);

        // conditional branch taken (ps^z=1)
        set_req(1'b1, 2'b01, 1'b0, 1'b1, 32'h80, '0);
        step(); chk_all("br_t", 32'h80, 1'b1, 1'b1, 2'd2);
        set_req(1'b0, 2'b00, 1'b0, 1'b0, '0, '0);
        step(); chk_all("br_f1", 32'h81, 1'b1, 1'b0, 2'd2);
        step(); chk_all("br_f2", 32'h82, 1'b0, 1'b0, 2'd2);

        // conditional branch not taken (ps^z=0)
        set_req(1'b1, 2'b01, 1'b1, 1'b1, 32'h80, '0);
        step(); chk_all("br_nt", 32'h83, 1'b0, 1'b0, 2'd2);

        // stalled unconditional branch
        set_req(1'b1, 2'b11, 1'b0, 1'b0, 32'h40, '0);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk_all("stall", 32'h83, 1'b0, 1'b0, 2'd2);
        end
        bus.stall = 1'b0;
        step(); chk_all("br_uncond", 32'h40, 1'b1, 1'b1, 2'd3);

        // stall in the cycle after redirect keeps taken high
        set_req(1'b0, 2'b00, 1'b0, 1'b0, '0, '0);
        bus.stall = 1'b1;
        step(); chk_all("stall_tk", 32'h40, 1'b1, 1'b1, 2'd3);
        bus.stall = 1'b0;
        step(); chk_all("post_st1", 32'h41, 1'b1, 1'b0, 2'd3);
        step(); chk_all("post_st2", 32'h42, 1'b0, 1'b0, 2'd3);

        // cnt_clr honoured during stall
        bus.stall = 1'b1; bus.cnt_clr = 1'b1;
        step(); chk_all("clr_stall", 32'h42, 1'b0, 1'b0, 2'd0);
        bus.stall = 1'b0; bus.cnt_clr = 1'b0;

        // wrap-around of the PC
        set_req(1'b1, 2'b10, 1'b0, 1'b0, '0, 32'hFFFF_FFFD);
        step(); chk_all("wrap_j", 32'hFFFF_FFFD, 1'b1, 1'b1, 2'd1);
        set_req(1'b0, 2'b00, 1'b0, 1'b0, '0, '0);
        step(); step(); chk_all("wrap_ff", 32'hFFFF_FFFF, 1'b0, 1'b0, 2'd1);
        chk("wrap.pc_inc", 64'(bus.pc_inc), 64'h0);
        step(); chk_all("wrap_0", 32'h0, 1'b0, 1'b0, 2'd1);

        // counter saturation at 3
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, 2'b11, 1'b0, 1'b0, 32'h100, '0);
            step();
            chk_all("sat", 32'h100, 1'b1, 1'b1, (i == 0) ? 2'd2 : 2'd3);
            set_req(1'b0, 2'b00, 1'b0, 1'b0, '0, '0);
            step(); step();
        end
        chk_all("sat_end", 32'h102, 1'b0, 1'b0, 2'd3);

        // clear and redirect on the same edge
        set_req(1'b1, 2'b11, 1'b0, 1'b0, 32'h300, '0);
        bus.cnt_clr = 1'b1;
        step(); chk_all("clr_redir", 32'h300, 1'b1, 1'b1, 2'd1);
        bus.cnt_clr = 1'b0;
        set_req(1'b0, 2'b00, 1'b0, 1'b0, '0, '0);

        // asynchronous reset mid-FLUSH, away from the clock edge
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 32'h0, 1'b0, 1'b0, 2'd0);
        @(negedge clk); rst_n = 1'b1;
        step(); chk_all("post_rst", 32'h1, 1'b0, 1'b0, 2'd0);
        chk("post_rst.pc_inc", 64'(bus.pc_inc), 64'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
